// File: rtl/flappybird_soc_pio_pkg.sv
// -----------------------------------------------------------------------------
// flappybird_soc_pio_pkg
// Shared definitions for the Avalon-MM input PIO blocks in the flappybird SoC.
//   pio_addr_e : word addresses of the slave register map
//   EDGE_*     : encodings of the EDGE_TYPE parameter
// -----------------------------------------------------------------------------
package flappybird_soc_pio_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,   // synchronised pin value, read-only
        ADDR_DIR  = 2'd1,   // direction, always reads 0 (input-only port)
        ADDR_MASK = 2'd2,   // irq mask, read/write
        ADDR_EDGE = 2'd3    // edge-capture flags, write-1-to-clear
    } pio_addr_e;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/flappybird_soc_pio_sync_edge.sv
// -----------------------------------------------------------------------------
// flappybird_soc_pio_sync_edge
// Two-flop synchroniser for the external pins, a previous-value register and
// the edge-detect term, gated off for ARM_CYCLES cycles after reset so the
// synchroniser filling up with the pin level does not look like an edge.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   in_port      asynchronous external pins
//   sync_q       first synchroniser stage (the value software reads as DATA)
//   detect       per-bit edge pulse of the selected polarity, one cycle wide
//   arm_active   high while edge detection is still suppressed after reset
// -----------------------------------------------------------------------------
module flappybird_soc_pio_sync_edge
    import flappybird_soc_pio_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter int EDGE_TYPE  = EDGE_RISE,
    parameter int ARM_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_q,
    output logic [WIDTH-1:0] detect,
    output logic             arm_active
);

    localparam int ARM_W = (ARM_CYCLES < 2) ? 1 : $clog2(ARM_CYCLES + 1);

    logic [WIDTH-1:0] sync_qq;
    logic [WIDTH-1:0] prev;
    logic [ARM_W-1:0] arm_cnt;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            sync_qq <= '0;
            prev    <= '0;
            arm_cnt <= ARM_W'(ARM_CYCLES);
        end else begin
            sync_q  <= in_port;
            sync_qq <= sync_q;
            prev    <= sync_qq;
            // Counts down once after reset and then parks at zero.
            if (arm_cnt != '0) begin
                arm_cnt <= arm_cnt - 1'b1;
            end
        end
    end

    assign rise       = sync_qq & ~prev;
    assign fall       = ~sync_qq & prev;
    assign arm_active = (arm_cnt != '0);

    always_comb begin
        edge_sel = rise;
        case (EDGE_TYPE)
            EDGE_FALL: edge_sel = fall;
            EDGE_ANY:  edge_sel = rise | fall;
            default:   edge_sel = rise;
        endcase
    end

    assign detect = arm_active ? '0 : edge_sel;

endmodule

// File: rtl/flappybird_soc_usb_irq_pio.sv
// -----------------------------------------------------------------------------
// flappybird_soc_usb_irq_pio
// Avalon-MM input PIO for the USB controller interrupt/status pins. Captures
// selected pin edges into write-1-to-clear flags and drives a registered level
// irq whenever an unmasked flag is set.
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   address, chipselect    slave word address and select
//   read_n, write_n        active-low read / write strobes
//   writedata              32-bit write data (bits above WIDTH ignored)
//   in_port                asynchronous external pins
//   readdata               read data, registered, valid one cycle after strobe
//   irq                    registered level interrupt
// -----------------------------------------------------------------------------
module flappybird_soc_usb_irq_pio
    import flappybird_soc_pio_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter int EDGE_TYPE  = EDGE_RISE,
    parameter int ARM_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // Bus handshake: there is no waitrequest, so the slave is always ready.
    // A cycle with chipselect high and write_n low is one complete write,
    // committed at that clock edge. A cycle with chipselect high and read_n low
    // is one complete read; readdata is registered at that edge and is valid
    // from then until the next read updates it.

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] detect;
    logic             arm_active;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] clr;
    logic [31:0]      rd_mux;
    logic             wr_en;
    logic             rd_en;
    logic             wdata_unused;
    logic             arm_unused;

    flappybird_soc_pio_sync_edge #(
        .WIDTH      (WIDTH),
        .EDGE_TYPE  (EDGE_TYPE),
        .ARM_CYCLES (ARM_CYCLES)
    ) u_sync_edge (
        .clk        (clk),
        .reset      (reset),
        .in_port    (in_port),
        .sync_q     (sync_q),
        .detect     (detect),
        .arm_active (arm_active)
    );

    assign wr_en = chipselect & ~write_n;
    assign rd_en = chipselect & ~read_n;
    assign clr   = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    // Bits above WIDTH are ignored on writes; arm_active is only a debug tap.
    assign wdata_unused = ^writedata;
    assign arm_unused   = arm_active;

    // Read mux sees register values before this cycle's write, so a read and
    // write to the same address in one cycle returns the old contents.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: rd_mux[WIDTH-1:0] = sync_q;
            ADDR_DIR:  rd_mux            = '0;
            ADDR_MASK: rd_mux[WIDTH-1:0] = mask;
            ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_cap;
            default:   rd_mux            = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask     <= '0;
            edge_cap <= '0;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_en && address == ADDR_MASK) begin
                mask <= writedata[WIDTH-1:0];
            end
            // A new edge in the same cycle as its clear keeps the flag set.
            edge_cap <= detect | (edge_cap & ~clr);
            if (rd_en) begin
                readdata <= rd_mux;
            end
            irq <= |(edge_cap & mask);
        end
    end

endmodule

// File: tb/tb_flappybird_soc_usb_irq_pio.sv
// -----------------------------------------------------------------------------
// tb_flappybird_soc_usb_irq_pio
// Directed bench for the USB irq input PIO. dut_a is a 4-bit rising-edge port,
// dut_b a 4-bit any-edge port; they share the bus but have separate selects.
// -----------------------------------------------------------------------------
module tb_flappybird_soc_usb_irq_pio;

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_DIR  = 2'd1;
    localparam logic [1:0] A_MASK = 2'd2;
    localparam logic [1:0] A_EDGE = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        cs_a, cs_b;
    logic        read_n, write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port_a, in_port_b;
    logic [31:0] rd_a, rd_b;
    logic        irq_a, irq_b;
    logic [31:0] rdv;

    int n_checks = 0;
    int n_pass   = 0;

    // clock / reset
    always #5 clk = ~clk;

    flappybird_soc_usb_irq_pio #(.WIDTH(4), .EDGE_TYPE(0), .ARM_CYCLES(3)) dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs_a),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .in_port(in_port_a), .readdata(rd_a), .irq(irq_a)
    );

    flappybird_soc_usb_irq_pio #(.WIDTH(4), .EDGE_TYPE(2), .ARM_CYCLES(3)) dut_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs_b),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .in_port(in_port_b), .readdata(rd_b), .irq(irq_b)
    );

    // checker
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic sel_b, input logic [1:0] addr, input logic [31:0] data);
        cs_a = ~sel_b; cs_b = sel_b;
        address = addr; writedata = data; write_n = 1'b0;
        tick();
        write_n = 1'b1; cs_a = 1'b0; cs_b = 1'b0;
    endtask

    task automatic bus_read(input logic sel_b, input logic [1:0] addr, output logic [31:0] data);
        cs_a = ~sel_b; cs_b = sel_b;
        address = addr; read_n = 1'b0;
        tick();
        data = sel_b ? rd_b : rd_a;
        read_n = 1'b1; cs_a = 1'b0; cs_b = 1'b0;
    endtask

    initial begin
        reset = 1'b1; address = '0; cs_a = 1'b0; cs_b = 1'b0;
        read_n = 1'b1; write_n = 1'b1; writedata = '0;
        in_port_a = 4'b0001; in_port_b = 4'b0000;
        ticks(3);
        check("reset_rd_a", rd_a, 32'h0);
        check("reset_irq_a", {31'b0, irq_a}, 32'h0);
        check("reset_irq_b", {31'b0, irq_b}, 32'h0);
        reset = 1'b0;

        // 1: pin high through reset is not an edge
        ticks(6);
        bus_read(1'b0, A_DATA, rdv); check("t1_data", rdv, 32'h1);
        bus_read(1'b0, A_EDGE, rdv); check("t1_edge", rdv, 32'h0);
        bus_read(1'b0, A_DIR,  rdv); check("t1_dir",  rdv, 32'h0);
        bus_read(1'b0, A_MASK, rdv); check("t1_mask", rdv, 32'h0);
        check("t1_irq", {31'b0, irq_a}, 32'h0);

        // falling edge ignored in rise mode
        in_port_a = 4'b0000;
        ticks(5);
        bus_read(1'b0, A_EDGE, rdv); check("fall_ignored", rdv, 32'h0);

        // 2: rising edge timing with mask on
        bus_write(1'b0, A_MASK, 32'h1);
        bus_read(1'b0, A_MASK, rdv); check("t2_mask", rdv, 32'h1);
        in_port_a = 4'b0001;
        ticks(2);
        check("t2_irq_e2", {31'b0, irq_a}, 32'h0);
        cs_a = 1'b1; address = A_EDGE; read_n = 1'b0;
        tick();
        check("t2_edge_pre_e3", rd_a, 32'h0);
        check("t2_irq_e3", {31'b0, irq_a}, 32'h0);
        tick();
        check("t2_edge_e4", rd_a, 32'h1);
        check("t2_irq_e4", {31'b0, irq_a}, 32'h1);
        read_n = 1'b1; cs_a = 1'b0;

        // 3: W1C drops irq one cycle after the write
        bus_write(1'b0, A_EDGE, 32'h1);
        check("t3_irq_w", {31'b0, irq_a}, 32'h1);
        tick();
        check("t3_irq_w1", {31'b0, irq_a}, 32'h0);
        bus_read(1'b0, A_EDGE, rdv); check("t3_edge", rdv, 32'h0);

        // 4: clear in the same cycle as a new detect keeps the flag
        in_port_a = 4'b0000; ticks(4);
        in_port_a = 4'b0001; ticks(4);
        check("t4_irq_set", {31'b0, irq_a}, 32'h1);
        in_port_a = 4'b0000; ticks(4);
        in_port_a = 4'b0001; ticks(2);
        bus_write(1'b0, A_EDGE, 32'h1);
        check("t4_irq_w", {31'b0, irq_a}, 32'h1);
        tick();
        check("t4_irq_w1", {31'b0, irq_a}, 32'h1);
        bus_read(1'b0, A_EDGE, rdv); check("t4_edge", rdv, 32'h1);

        // 5: masked flag, then unmask
        bus_write(1'b0, A_MASK, 32'h0);
        tick();
        check("t5_irq_masked", {31'b0, irq_a}, 32'h0);
        bus_write(1'b0, A_EDGE, 32'h1);
        bus_read(1'b0, A_EDGE, rdv); check("t5_edge_clr", rdv, 32'h0);
        in_port_a = 4'b0000; ticks(4);
        in_port_a = 4'b0001; ticks(4);
        bus_read(1'b0, A_EDGE, rdv); check("t5_edge_set", rdv, 32'h1);
        check("t5_irq_off", {31'b0, irq_a}, 32'h0);
        bus_write(1'b0, A_EDGE, 32'h0);
        bus_read(1'b0, A_EDGE, rdv); check("t3_w0_noeffect", rdv, 32'h1);
        bus_write(1'b0, A_MASK, 32'h1);
        check("t5_irq_w", {31'b0, irq_a}, 32'h0);
        tick();
        check("t5_irq_w1", {31'b0, irq_a}, 32'h1);

        // read and write EDGE in one cycle returns the pre-write value
        cs_a = 1'b1; address = A_EDGE; writedata = 32'h1; read_n = 1'b0; write_n = 1'b0;
        tick();
        check("rw_same_cycle", rd_a, 32'h1);
        read_n = 1'b1; write_n = 1'b1; cs_a = 1'b0;
        bus_read(1'b0, A_EDGE, rdv); check("rw_after", rdv, 32'h0);

        // upper bits ignored on write, read back as zero
        bus_write(1'b0, A_MASK, 32'hFFFF_FFFF);
        bus_read(1'b0, A_MASK, rdv); check("mask_width", rdv, 32'hF);

        // 6: any-edge port, pin 2 toggled high then low
        in_port_b = 4'b0100; ticks(4);
        bus_read(1'b1, A_EDGE, rdv); check("t6_edge_rise", rdv, 32'h4);
        bus_write(1'b1, A_EDGE, 32'h4);
        in_port_b = 4'b0000; ticks(4);
        bus_read(1'b1, A_EDGE, rdv); check("t6_edge_fall", rdv, 32'h4);
        bus_read(1'b1, A_DATA, rdv); check("t6_data", rdv, 32'h0);

        // reset during a toggle
        in_port_b = 4'b0100; ticks(2);
        reset = 1'b1;
        tick();
        in_port_b = 4'b0000;
        tick();
        check("t6_rst_rd_b", rd_b, 32'h0);
        check("t6_rst_irq_a", {31'b0, irq_a}, 32'h0);
        reset = 1'b0;
        ticks(6);
        bus_read(1'b1, A_DATA, rdv); check("t6_b_data", rdv, 32'h0);
        bus_read(1'b1, A_DIR,  rdv); check("t6_b_dir",  rdv, 32'h0);
        bus_read(1'b1, A_MASK, rdv); check("t6_b_mask", rdv, 32'h0);
        bus_read(1'b1, A_EDGE, rdv); check("t6_b_edge", rdv, 32'h0);
        bus_read(1'b0, A_MASK, rdv); check("t6_a_mask", rdv, 32'h0);
        bus_read(1'b0, A_EDGE, rdv); check("t6_a_edge", rdv, 32'h0);
        check("t6_irq_b", {31'b0, irq_b}, 32'h0);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
